// File: rtl/cpu_trace_checker_p.sv
// Trace stream checker: parses register-write and memory-write records one
// ASCII character per clock, flags range/alignment errors, latches the parsed
// fields of each complete record and keeps saturating record/error counters.
module cpu_trace_checker_p #(
    parameter int unsigned TIME_DIGITS = 4,
    parameter int unsigned GRF_DIGITS  = 4,
    parameter logic [31:0] GRF_MAX     = 32'd31,
    parameter logic [31:0] PC_LO       = 32'h0000_3000,
    parameter logic [31:0] PC_HI       = 32'h0000_4fff,
    parameter logic [31:0] ADDR_LO     = 32'h0000_0000,
    parameter logic [31:0] ADDR_HI     = 32'h0000_2fff,
    parameter int unsigned DATA_DIGITS = 8,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       char,
    input  logic [15:0]      freq,
    output logic [1:0]       format_type,
    output logic [3:0]       error_code,
    output logic [31:0]      rec_pc,
    output logic [31:0]      rec_target,
    output logic [31:0]      rec_data,
    output logic [CNT_W-1:0] rec_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_TIME = 4'd1;
    localparam logic [3:0] S_PC   = 4'd2;
    localparam logic [3:0] S_SP1  = 4'd3;
    localparam logic [3:0] S_GRF  = 4'd4;
    localparam logic [3:0] S_ADDR = 4'd5;
    localparam logic [3:0] S_SP2  = 4'd6;
    localparam logic [3:0] S_LT   = 4'd7;
    localparam logic [3:0] S_EQ   = 4'd8;
    localparam logic [3:0] S_DATA = 4'd9;
    localparam logic [3:0] S_DONE = 4'd10;

    localparam logic [3:0]       TimeMax = 4'(TIME_DIGITS);
    localparam logic [3:0]       GrfMax  = 4'(GRF_DIGITS);
    localparam logic [3:0]       DataLen = 4'(DATA_DIGITS);
    localparam logic [CNT_W-1:0] CntMax  = '1;

    logic [3:0]       st_q, st_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [31:0]      tv_q, tv_d, pc_q, pc_d, tgt_q, tgt_d, data_q, data_d;
    logic [3:0]       err_q, err_d;
    logic             mem_q, mem_d;
    logic             done_upd, go_idle;
    logic             is_dec, is_hex;
    logic [3:0]       dig_val, cnt_inc;
    logic [31:0]      tmask;
    int unsigned      msb_idx;
    logic             time_err, pc_bad, addr_bad;
    logic [31:0]      rec_pc_q, rec_target_q, rec_data_q;
    logic [CNT_W-1:0] rec_count_q, err_count_q;

    // Character classification and digit value.
    always_comb begin
        is_dec  = (char >= "0") && (char <= "9");
        is_hex  = is_dec || ((char >= "a") && (char <= "f"));
        dig_val = is_dec ? char[3:0] : char[3:0] + 4'd9;
        cnt_inc = (cnt_q == 4'hf) ? cnt_q : cnt_q + 4'd1;
    end

    // Range checks; time must be a multiple of 2^(m-1), m = msb index of freq.
    always_comb begin
        msb_idx = 0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (freq[i]) msb_idx = i;
        end
        tmask = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            tmask[i] = (i + 1 < msb_idx);
        end
        time_err = (msb_idx >= 2) && ((tv_q & tmask) != 32'd0);
        // Single unsigned compare covers both bounds without constant-zero tests.
        pc_bad   = ((pc_q - PC_LO) > (PC_HI - PC_LO)) || (pc_q[1:0] != 2'b00);
        addr_bad = ((tgt_q - ADDR_LO) > (ADDR_HI - ADDR_LO)) || (tgt_q[1:0] != 2'b00);
    end

    // Record parser next-state.
    always_comb begin
        st_d = st_q;  cnt_d = cnt_q;  tv_d = tv_q;  pc_d = pc_q;
        tgt_d = tgt_q;  data_d = data_q;  err_d = err_q;  mem_d = mem_q;
        done_upd = 1'b0;
        go_idle  = 1'b0;
        if (char == "^") begin
            st_d = S_TIME;  cnt_d = '0;  tv_d = '0;  pc_d = '0;
            tgt_d = '0;  data_d = '0;  err_d = '0;  mem_d = 1'b0;
        end else begin
            case (st_q)
                S_TIME: begin
                    if (is_dec) begin
                        tv_d  = tv_q * 32'd10 + {28'd0, dig_val};
                        cnt_d = cnt_inc;
                    end else if (char == "@" && cnt_q != 4'd0 && cnt_q <= TimeMax) begin
                        st_d     = S_PC;
                        cnt_d    = '0;
                        err_d[0] = time_err;
                    end else go_idle = 1'b1;
                end
                S_PC: begin
                    if (is_hex) begin
                        pc_d  = {pc_q[27:0], dig_val};
                        cnt_d = cnt_inc;
                    end else if (char == ":" && cnt_q == 4'd8) begin
                        st_d     = S_SP1;
                        err_d[1] = pc_bad;
                    end else go_idle = 1'b1;
                end
                S_SP1: begin
                    if (char == "$") begin
                        st_d = S_GRF;  cnt_d = '0;  mem_d = 1'b0;
                    end else if (char == "*") begin
                        st_d = S_ADDR;  cnt_d = '0;  mem_d = 1'b1;
                    end else if (char != " ") go_idle = 1'b1;
                end
                S_GRF: begin
                    if (is_dec) begin
                        tgt_d = tgt_q * 32'd10 + {28'd0, dig_val};
                        cnt_d = cnt_inc;
                    end else if ((char == " " || char == "<") && cnt_q != 4'd0
                                 && cnt_q <= GrfMax) begin
                        st_d     = (char == " ") ? S_SP2 : S_LT;
                        err_d[3] = (tgt_q > GRF_MAX);
                    end else go_idle = 1'b1;
                end
                S_ADDR: begin
                    if (is_hex) begin
                        tgt_d = {tgt_q[27:0], dig_val};
                        cnt_d = cnt_inc;
                    end else if ((char == " " || char == "<") && cnt_q == 4'd8) begin
                        st_d     = (char == " ") ? S_SP2 : S_LT;
                        err_d[2] = addr_bad;
                    end else go_idle = 1'b1;
                end
                S_SP2: begin
                    if (char == "<") st_d = S_LT;
                    else if (char != " ") go_idle = 1'b1;
                end
                S_LT: begin
                    if (char == "=") st_d = S_EQ;
                    else go_idle = 1'b1;
                end
                S_EQ: begin
                    if (is_hex) begin
                        st_d = S_DATA;  data_d = {28'd0, dig_val};  cnt_d = 4'd1;
                    end else if (char != " ") go_idle = 1'b1;
                end
                S_DATA: begin
                    if (is_hex) begin
                        data_d = {data_q[27:0], dig_val};
                        cnt_d  = cnt_inc;
                    end else if (char == "#" && cnt_q == DataLen) begin
                        st_d     = S_DONE;
                        done_upd = 1'b1;
                    end else go_idle = 1'b1;
                end
                default: go_idle = 1'b1;
            endcase
            if (go_idle) begin
                st_d = S_IDLE;  cnt_d = '0;  tv_d = '0;  pc_d = '0;
                tgt_d = '0;  data_d = '0;  err_d = '0;  mem_d = 1'b0;
            end
        end
    end

    // Parser state, accumulators and record/counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q <= S_IDLE;  cnt_q <= '0;  tv_q <= '0;  pc_q <= '0;
            tgt_q <= '0;  data_q <= '0;  err_q <= '0;  mem_q <= 1'b0;
            rec_pc_q <= '0;  rec_target_q <= '0;  rec_data_q <= '0;
            rec_count_q <= '0;  err_count_q <= '0;
        end else begin
            st_q <= st_d;  cnt_q <= cnt_d;  tv_q <= tv_d;  pc_q <= pc_d;
            tgt_q <= tgt_d;  data_q <= data_d;  err_q <= err_d;  mem_q <= mem_d;
            if (done_upd) begin
                rec_pc_q     <= pc_q;
                rec_target_q <= tgt_q;
                rec_data_q   <= data_q;
                if (rec_count_q != CntMax) rec_count_q <= rec_count_q + 1'b1;
                if (err_q != 4'd0 && err_count_q != CntMax) err_count_q <= err_count_q + 1'b1;
            end
        end
    end

    // Record report is visible only while sitting in DONE.
    always_comb begin
        format_type = (st_q == S_DONE) ? (mem_q ? 2'b10 : 2'b01) : 2'b00;
        error_code  = (st_q == S_DONE) ? err_q : 4'd0;
    end

    assign rec_pc     = rec_pc_q;
    assign rec_target = rec_target_q;
    assign rec_data   = rec_data_q;
    assign rec_count  = rec_count_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_cpu_trace_checker_p.sv
// Scoreboard bench for cpu_trace_checker_p: directed records from the test plan
// plus randomized records, expected reports queued at stimulus time and popped
// by a monitor whenever the checker reports a record.
module tb_cpu_trace_checker_p;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  char = 8'd0;
    logic [15:0] freq = 16'd0;

    logic [1:0]  format_type, format_type2;
    logic [3:0]  error_code, error_code2;
    logic [31:0] rec_pc, rec_target, rec_data, rec_pc2, rec_target2, rec_data2;
    logic [15:0] rec_count, err_count;
    logic [1:0]  rec_count2, err_count2;

    cpu_trace_checker_p dut (
        .clk(clk), .reset(reset), .char(char), .freq(freq),
        .format_type(format_type), .error_code(error_code),
        .rec_pc(rec_pc), .rec_target(rec_target), .rec_data(rec_data),
        .rec_count(rec_count), .err_count(err_count)
    );

    cpu_trace_checker_p #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .char(char), .freq(freq),
        .format_type(format_type2), .error_code(error_code2),
        .rec_pc(rec_pc2), .rec_target(rec_target2), .rec_data(rec_data2),
        .rec_count(rec_count2), .err_count(err_count2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  fmt;
        logic [3:0]  err;
        logic [31:0] pc, tgt, data;
        int unsigned rc, ec;
    } exp_t;

    exp_t        sb[$];
    exp_t        me;
    int          checks = 0;
    int          errors = 0;
    int unsigned m_rc = 0;
    int unsigned m_ec = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int unsigned sat3(input int unsigned v);
        return (v > 3) ? 3 : v;
    endfunction

    // Monitor: every reported record must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset) begin
            if (format_type != 2'b00) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_record: got format %0d expected none", format_type);
                end else begin
                    me = sb.pop_front();
                    chk("format_type", 32'(format_type), 32'(me.fmt));
                    chk("error_code", 32'(error_code), 32'(me.err));
                    chk("rec_pc", rec_pc, me.pc);
                    chk("rec_target", rec_target, me.tgt);
                    chk("rec_data", rec_data, me.data);
                    chk("rec_count", 32'(rec_count), me.rc);
                    chk("err_count", 32'(err_count), me.ec);
                    chk("w2_format_type", 32'(format_type2), 32'(me.fmt));
                    chk("w2_rec_count", 32'(rec_count2), sat3(me.rc));
                    chk("w2_err_count", 32'(err_count2), sat3(me.ec));
                end
            end else begin
                chk("idle_error_code", 32'(error_code), 32'd0);
                chk("w2_idle_format", 32'(format_type2), 32'd0);
            end
        end
    end

    task automatic send(input byte c);
        @(negedge clk);
        char = c;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    // Drive one record; a good one queues its expected report with the final char.
    task automatic record(input string s, input logic [15:0] f, input bit good,
                          input logic [1:0] fmt, input logic [3:0] err,
                          input logic [31:0] pc, input logic [31:0] tgt,
                          input logic [31:0] data);
        exp_t e;
        freq = f;
        for (int i = 0; i < s.len() - 1; i++) send(s[i]);
        @(negedge clk);
        if (good) begin
            m_rc++;
            if (err != 4'd0) m_ec++;
            e.fmt = fmt;  e.err = err;  e.pc = pc;  e.tgt = tgt;  e.data = data;
            e.rc = m_rc;  e.ec = m_ec;
            sb.push_back(e);
        end
        char = s[s.len() - 1];
    endtask

    function automatic string spaces(input int n);
        string s = "";
        repeat (n) s = {s, " "};
        return s;
    endfunction

    // Reference rule: time must be a multiple of 2^(m-1) when m >= 2.
    function automatic bit time_bad(input logic [31:0] t, input logic [15:0] f);
        int m = -1;
        for (int i = 0; i < 16; i++) if (f[i]) m = i;
        if (m < 2) return 1'b0;
        return (t % (32'd1 << (m - 1))) != 0;
    endfunction

    task automatic rand_record();
        int          kind;
        bit          mem, good;
        logic [31:0] tv, pc, tgt, data;
        logic [15:0] f;
        logic [3:0]  err;
        string       ts, ps, gs, ds, lt, s;
        kind = $urandom_range(0, 13);
        good = (kind <= 5);
        tv   = $urandom_range(0, 9999);
        case ($urandom_range(0, 5))
            0: f = 16'd0;
            1: f = 16'd1;
            2: f = 16'd2;
            3: f = 16'd4;
            4: f = 16'(32'd1 << $urandom_range(2, 15));
            default: f = 16'($urandom);
        endcase
        pc   = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(32'h2ff0, 32'h5010);
        mem  = 1'($urandom_range(0, 1));
        if (mem) tgt = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 32'h3010);
        else     tgt = $urandom_range(0, 40);
        data = $urandom;
        ts = $sformatf("%0d", tv);
        ps = $sformatf("%08h", pc);
        gs = mem ? $sformatf("%08h", tgt) : $sformatf("%0d", tgt);
        ds = $sformatf("%08h", data);
        lt = "<=";
        case (kind)
            6:  ts = $sformatf("%0d", $urandom_range(10000, 99999));
            7:  ps = {ps, "0"};
            8:  ps = ps.substr(1, 7);
            9:  ds = {ds.substr(0, 6), "A"};
            10: ds = ds.substr(0, 6);
            11: ts = "";
            12: gs = mem ? {gs, "0"} : $sformatf("%05d", tgt);
            13: lt = "< =";
            default: ;
        endcase
        s = {"^", ts, "@", ps, ":", spaces($urandom_range(0, 2)), mem ? "*" : "$", gs,
             spaces($urandom_range(0, 2)), lt, spaces($urandom_range(0, 2)), ds, "#"};
        err[0] = time_bad(tv, f);
        err[1] = (pc < 32'h3000) || (pc > 32'h4fff) || (pc % 4 != 0);
        err[2] = mem && ((tgt > 32'h2fff) || (tgt % 4 != 0));
        err[3] = !mem && (tgt > 31);
        record(s, f, good, mem ? 2'b10 : 2'b01, err, pc, tgt, data);
        case ($urandom_range(0, 3))
            0: send("x");
            1: send(" ");
            2: send(8'h0a);
            default: ;
        endcase
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_format", 32'(format_type), 32'd0);
        chk("reset_error", 32'(error_code), 32'd0);
        chk("reset_rec_pc", rec_pc, 32'd0);
        chk("reset_rec_target", rec_target, 32'd0);
        chk("reset_rec_data", rec_data, 32'd0);
        chk("reset_rec_count", 32'(rec_count), 32'd0);
        chk("reset_err_count", 32'(err_count), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        record("^10@00003000: $1 <= 0000000a#", 16'd4, 1'b1, 2'b01, 4'b0000,
               32'h3000, 32'd1, 32'ha);
        record("^11@00002ffc: *00000ffe <= 12345678#", 16'd4, 1'b1, 2'b10, 4'b0111,
               32'h2ffc, 32'hffe, 32'h1234_5678);
        record("^5@00003004: $32<=ffffffff#", 16'd1, 1'b1, 2'b01, 4'b1000,
               32'h3004, 32'd32, 32'hffff_ffff);
        send("x");
        @(posedge clk);
        #1;
        chk("after_x_format", 32'(format_type), 32'd0);

        record("^1@000030000: $1 <= 00000000#", 16'd4, 1'b0, 2'b00, 4'd0, 0, 0, 0);
        record("^12345@00003000: $1 <= 00000000#", 16'd4, 1'b0, 2'b00, 4'd0, 0, 0, 0);
        record("^1@0000300A: $1 <= 00000000#", 16'd4, 1'b0, 2'b00, 4'd0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("malformed_rec_count", 32'(rec_count), m_rc);

        record("^1@00003000: $1 <^2@00003008: $2 <= 00000001#", 16'd4, 1'b1, 2'b01,
               4'b0000, 32'h3008, 32'd2, 32'd1);

        send_str("^4@00003000: $7 <= 00");
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midreset_format", 32'(format_type), 32'd0);
        chk("midreset_rec_count", 32'(rec_count), 32'd0);
        chk("midreset_err_count", 32'(err_count), 32'd0);
        chk("midreset_rec_pc", rec_pc, 32'd0);
        m_rc = 0;
        m_ec = 0;
        @(negedge clk);
        reset = 1'b1;
        send_str("0000");
        record("^10@00003000: $1 <= 0000000a#", 16'd4, 1'b1, 2'b01, 4'b0000,
               32'h3000, 32'd1, 32'ha);
        @(posedge clk);
        #1;
        chk("post_reset_rec_count", 32'(rec_count), 32'd1);

        for (int i = 0; i < 4; i++) begin
            record($sformatf("^8@%08h: $%0d <= %08h#", 32'h3000 + 4 * i, i, i), 16'd8,
                   1'b1, 2'b01, 4'b0000, 32'h3000 + 4 * i, i, i);
        end
        @(posedge clk);
        #1;
        chk("five_rec_count", 32'(rec_count), 32'd5);
        chk("w2_saturated_count", 32'(rec_count2), 32'd3);

        for (int i = 0; i < 150; i++) rand_record();

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        chk("final_rec_count", 32'(rec_count), m_rc);
        chk("final_err_count", 32'(err_count), m_ec);
        chk("w2_final_rec_count", 32'(rec_count2), sat3(m_rc));
        chk("w2_final_err_count", 32'(err_count2), sat3(m_ec));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
